// File: rtl/tt_um_serial_subtractor_if.sv
// Standard tile pin bundle for tt_um_serial_subtractor.
// The master drives the tile inputs and the slave (the tile) drives the outputs.
interface tt_um_serial_subtractor_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial A-B subtractor (LSB first) with a parallel result on uio_out.
// Defining SERIAL_SUB_ADD_EN adds a per-word add mode selected by ui_in[4] at start.
module tt_um_serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tt_um_serial_subtractor_if.slave      pins
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [3:0]       count;
  logic             borrow;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] result;
  logic             diff_bit;
  logic             borrow_out;
  logic             done;

  logic             a_bit, b_bit, valid, start;
  logic             accept, bin, d, bout, finish;
  logic [3:0]       count_next;
  logic [WIDTH-1:0] sh_next;

  assign a_bit = pins.ui_in[0];
  assign b_bit = pins.ui_in[1];
  assign valid = pins.ui_in[2];
  assign start = pins.ui_in[3];

  // A start bit is always taken; plain bits only while a word is in flight.
  assign accept     = valid & (start | (state == SHIFT));
  assign bin        = start ? 1'b0 : borrow;
  assign count_next = start ? 4'd1 : count + 4'd1;
  assign finish     = accept && (count_next == 4'(WIDTH));

`ifdef SERIAL_SUB_ADD_EN
  logic mode_r;
  logic mode_eff;

  assign mode_eff = start ? pins.ui_in[4] : mode_r;

  always_comb begin
    d = a_bit ^ b_bit ^ bin;
    if (mode_eff) bout = (a_bit & b_bit) | ((a_bit ^ b_bit) & bin);
    else          bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
  end
`else
  always_comb begin
    d    = a_bit ^ b_bit ^ bin;
    bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
  end
`endif

  // New bits enter at the MSB so the finished word lands LSB-aligned.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign sh_next = d;
    end else begin : g_shift_many
      assign sh_next = {d, shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      borrow     <= 1'b0;
      shreg      <= '0;
      result     <= '0;
      diff_bit   <= 1'b0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
      mode_r     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        diff_bit <= d;
        borrow   <= bout;
        shreg    <= sh_next;
        count    <= count_next;
`ifdef SERIAL_SUB_ADD_EN
        if (start) mode_r <= pins.ui_in[4];
`endif
        if (finish) begin
          result     <= sh_next;
          borrow_out <= bout;
          done       <= 1'b1;
          state      <= IDLE;
          count      <= '0;
        end else begin
          state <= SHIFT;
        end
      end
    end
  end

  assign pins.uo_out  = {4'b0000, (state == SHIFT), done, borrow_out, diff_bit};
  assign pins.uio_out = 8'(result);
  assign pins.uio_oe  = '1;

`ifdef SERIAL_SUB_ADD_EN
  logic unused_pins;
  assign unused_pins = &{1'b0, pins.ena, pins.uio_in, pins.ui_in[7:5]};
`else
  logic unused_pins;
  assign unused_pins = &{1'b0, pins.ena, pins.uio_in, pins.ui_in[7:4]};
`endif

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Scoreboard bench for tt_um_serial_subtractor: stimulus queues expected diff bits
// and results, a monitor checks them as the tile produces them.
module tb_tt_um_serial_subtractor;

  logic clk;
  logic rst_n;
  logic exp_accept;
  int   tests;
  int   failed;

  logic       diff_q[$];
  logic [8:0] res_q[$];

  tt_um_serial_subtractor_if pins();

  tt_um_serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (pins.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    pins.ui_in = 8'h00;
    exp_accept = 1'b0;
  endtask

  // Sends nbits of A/B; full words also queue the expected parallel result.
  task automatic send_word(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_w, input logic exp_b,
                           input int gap, input int nbits, input logic full);
    logic mode;
    if (full) res_q.push_back({exp_b, exp_w});
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mode = (i == 0) ? 1'b1 : i[0];
      pins.ui_in = {3'b000, mode, (i == 0), 1'b1, b[i], a[i]};
      diff_q.push_back(exp_w[i]);
      exp_accept = 1'b1;
      if (i < nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          idle_cycle();
          check("busy_in_gap", {7'd0, pins.uo_out[3]}, 8'h01);
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the tile presents a bit or a result.
  initial begin
    logic       e;
    logic [8:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (exp_accept) begin
          if (diff_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL diff_underflow: no expected bit queued at %0t", $time);
          end else begin
            e = diff_q.pop_front();
            check("diff_bit", {7'd0, pins.uo_out[0]}, {7'd0, e});
          end
        end
        if (pins.uo_out[2]) begin
          if (res_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
          end else begin
            r = res_q.pop_front();
            check("uio_out", pins.uio_out, r[7:0]);
            check("borrow_out", {7'd0, pins.uo_out[1]}, {7'd0, r[8]});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    failed = 0;
    exp_accept = 1'b0;
    pins.ena = 1'b1;
    pins.ui_in = 8'h00;
    pins.uio_in = 8'h00;
    rst_n = 1'b0;
    #1;
    check("rst_uo_out", pins.uo_out, 8'h00);
    check("rst_uio_out", pins.uio_out, 8'h00);
    check("rst_uio_oe", pins.uio_oe, 8'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // valid without start in IDLE is ignored
    @(negedge clk);
    pins.ui_in = 8'b0000_0111;
    exp_accept = 1'b0;
    idle_cycle();
    check("idle_ignore_busy", {7'd0, pins.uo_out[3]}, 8'h00);

    // back-to-back words, no gaps
    send_word(8'h05, 8'h03, 8'h02, 1'b0, 0, 8, 1'b1);
    send_word(8'h03, 8'h05, 8'hFE, 1'b1, 0, 8, 1'b1);
    send_word(8'h00, 8'h01, 8'hFF, 1'b1, 0, 8, 1'b1);
    send_word(8'hA5, 8'hA5, 8'h00, 1'b0, 0, 8, 1'b1);
    idle_cycle();
    check("idle_after_word_busy", {7'd0, pins.uo_out[3]}, 8'h00);

    // three idle cycles between every bit
    send_word(8'h80, 8'h01, 8'h7F, 1'b0, 3, 8, 1'b1);
    idle_cycle();
    idle_cycle();

    // abort after 4 bits, restart with a fresh word
    send_word(8'hFF, 8'h00, 8'hFF, 1'b0, 0, 4, 1'b0);
    idle_cycle();
    check("abort_busy_held", {7'd0, pins.uo_out[3]}, 8'h01);
    check("abort_result_held", pins.uio_out, 8'h7F);
    send_word(8'h02, 8'h01, 8'h01, 1'b0, 0, 8, 1'b1);
    idle_cycle();
    idle_cycle();

    // reset after 5 bits of a word
    send_word(8'h33, 8'h11, 8'h22, 1'b0, 0, 5, 1'b0);
    @(negedge clk);
    pins.ui_in = 8'h00;
    exp_accept = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midword_rst_uo_out", pins.uo_out, 8'h00);
    check("midword_rst_uio_out", pins.uio_out, 8'h00);
    check("midword_rst_uio_oe", pins.uio_oe, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_word(8'h09, 8'h04, 8'h05, 1'b0, 0, 8, 1'b1);
    idle_cycle();

    // mode bit on start, toggled mid-word
`ifdef SERIAL_SUB_ADD_EN
    send_word(8'hF0, 8'h20, 8'h10, 1'b1, 0, 8, 1'b1);
`else
    send_word(8'hF0, 8'h20, 8'hD0, 1'b0, 0, 8, 1'b1);
`endif
    repeat (4) idle_cycle();

    check("pending_results", 8'(res_q.size()), 8'h00);
    check("pending_diff_bits", 8'(diff_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
